// File: rtl/vga_layer_compositor_if.sv
`default_nettype none
// ============================================================================
//  Module      : vga_layer_compositor_if
//  Description : Pixel-path bundle between the timing/sprite sources, the
//                compositor and the VGA DAC pins.
//  Revision    : 1.0  initial release
// ============================================================================
interface vga_layer_compositor_if #(
    parameter int NUM_LAYERS = 4,
    parameter int COLOR_W    = 4
);
    logic                            hsync_in;
    logic                            vsync_in;
    logic                            display_en;
    logic                            frame_start;
    logic [NUM_LAYERS-1:0]           layer_active;
    logic [NUM_LAYERS*3*COLOR_W-1:0] layer_rgb;
    logic [NUM_LAYERS-1:0]           cfg_layer_en;
    logic [NUM_LAYERS-1:0]           cfg_blink;
    logic [3*COLOR_W-1:0]            cfg_bg_rgb;
    logic                            cfg_dim;
    logic [COLOR_W-1:0]              vga_r;
    logic [COLOR_W-1:0]              vga_g;
    logic [COLOR_W-1:0]              vga_b;
    logic                            vga_hsync;
    logic                            vga_vsync;
    logic [NUM_LAYERS-1:0]           collision;

    // Source side: timing generator, sprite engines and config registers
    modport master (
        output hsync_in, vsync_in, display_en, frame_start,
        output layer_active, layer_rgb,
        output cfg_layer_en, cfg_blink, cfg_bg_rgb, cfg_dim,
        input  vga_r, vga_g, vga_b, vga_hsync, vga_vsync, collision
    );

    // Compositor side
    modport slave (
        input  hsync_in, vsync_in, display_en, frame_start,
        input  layer_active, layer_rgb,
        input  cfg_layer_en, cfg_blink, cfg_bg_rgb, cfg_dim,
        output vga_r, vga_g, vga_b, vga_hsync, vga_vsync, collision
    );
endinterface
`default_nettype wire

// File: rtl/vga_layer_compositor.sv
`default_nettype none
// ============================================================================
//  Module      : vga_layer_compositor
//  Description : Fixed-priority sprite layer merge over a background colour,
//                with per-layer enable/blink, global dim, frame-shadowed
//                config, per-frame collision flags and sync realignment.
//                Two-cycle pipeline from inputs to DAC pins.
//  Revision    : 1.0  initial release
// ============================================================================
module vga_layer_compositor #(
    parameter int   NUM_LAYERS = 4,
    parameter int   COLOR_W    = 4,
    parameter int   BLINK_BIT  = 4,
    parameter logic SYNC_IDLE  = 1'b1
) (
    input  wire logic               clk_25mhz,
    input  wire logic               reset,
    vga_layer_compositor_if.slave   bus
);

    localparam int PIX_W = 3 * COLOR_W;

    // Frame-shadowed configuration
    logic [NUM_LAYERS-1:0] en_q, en_d;
    logic [NUM_LAYERS-1:0] blink_q, blink_d;
    logic [PIX_W-1:0]      bg_q, bg_d;
    logic                  dim_q, dim_d;
    logic [7:0]            frame_cnt_q, frame_cnt_d;

    // Collision tracking
    logic [NUM_LAYERS-1:0] acc_q, acc_d;
    logic [NUM_LAYERS-1:0] coll_q, coll_d;

    // Stage 1
    logic [PIX_W-1:0]      pix_q, pix_d;
    logic                  de_q, hs_q, vs_q;

    // Stage 2 (pins)
    logic [PIX_W-1:0]      rgb_q, rgb_d;
    logic                  hs2_q, vs2_q;

    logic [NUM_LAYERS-1:0] w_visible;
    logic                  w_multi;
    logic [NUM_LAYERS-1:0] w_acc_hit;

    // Visibility from the shadow values in force this cycle
    assign w_visible = bus.layer_active & en_q
                     & ~(blink_q & {NUM_LAYERS{frame_cnt_q[BLINK_BIT]}});

    // x & (x-1) clears the lowest set bit; non-zero means two or more hits.
    // Degenerates to 0 for a single layer, so collision stays 0 there.
    assign w_multi   = |(w_visible & (w_visible - NUM_LAYERS'(1)));
    assign w_acc_hit = acc_q | ((w_multi && bus.display_en) ? w_visible : '0);

    // Shadow config, frame counter and collision next-state
    always_comb begin
        en_d        = en_q;
        blink_d     = blink_q;
        bg_d        = bg_q;
        dim_d       = dim_q;
        frame_cnt_d = frame_cnt_q;
        acc_d       = w_acc_hit;
        coll_d      = coll_q;
        if (bus.frame_start) begin
            en_d        = bus.cfg_layer_en;
            blink_d     = bus.cfg_blink;
            bg_d        = bus.cfg_bg_rgb;
            dim_d       = bus.cfg_dim;
            frame_cnt_d = frame_cnt_q + 8'd1;
            coll_d      = w_acc_hit;
            acc_d       = '0;
        end
    end

    // Priority merge: lowest-index visible layer wins, background otherwise
    always_comb begin
        pix_d = bg_q;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (w_visible[i]) begin
                pix_d = bus.layer_rgb[i*PIX_W +: PIX_W];
            end
        end
    end

    // Blanking and optional per-channel halving for the pins
    always_comb begin
        rgb_d = '0;
        if (de_q) begin
            if (dim_q) begin
                rgb_d = {pix_q[3*COLOR_W-1 -: COLOR_W] >> 1,
                         pix_q[2*COLOR_W-1 -: COLOR_W] >> 1,
                         pix_q[COLOR_W-1   -: COLOR_W] >> 1};
            end else begin
                rgb_d = pix_q;
            end
        end
    end

    // All state, asynchronously reset so the pins go idle immediately
    always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset) begin
            en_q        <= '1;
            blink_q     <= '0;
            bg_q        <= '0;
            dim_q       <= 1'b0;
            frame_cnt_q <= 8'd0;
            acc_q       <= '0;
            coll_q      <= '0;
            pix_q       <= '0;
            de_q        <= 1'b0;
            hs_q        <= 1'b0;
            vs_q        <= 1'b0;
            rgb_q       <= '0;
            hs2_q       <= SYNC_IDLE;
            vs2_q       <= SYNC_IDLE;
        end else begin
            en_q        <= en_d;
            blink_q     <= blink_d;
            bg_q        <= bg_d;
            dim_q       <= dim_d;
            frame_cnt_q <= frame_cnt_d;
            acc_q       <= acc_d;
            coll_q      <= coll_d;
            pix_q       <= pix_d;
            de_q        <= bus.display_en;
            hs_q        <= bus.hsync_in;
            vs_q        <= bus.vsync_in;
            rgb_q       <= rgb_d;
            hs2_q       <= hs_q;
            vs2_q       <= vs_q;
        end
    end

    assign bus.vga_r     = rgb_q[3*COLOR_W-1 -: COLOR_W];
    assign bus.vga_g     = rgb_q[2*COLOR_W-1 -: COLOR_W];
    assign bus.vga_b     = rgb_q[COLOR_W-1   -: COLOR_W];
    assign bus.vga_hsync = hs2_q;
    assign bus.vga_vsync = vs2_q;
    assign bus.collision = coll_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_layer_compositor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_layer_compositor
//  Description : Directed self-checking bench for vga_layer_compositor.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vga_layer_compositor;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    int   nf       = 0;

    vga_layer_compositor_if #(.NUM_LAYERS(4), .COLOR_W(4)) bus ();

    vga_layer_compositor #(
        .NUM_LAYERS (4),
        .COLOR_W    (4),
        .BLINK_BIT  (4),
        .SYNC_IDLE  (1'b1)
    ) dut (
        .clk_25mhz (clk),
        .reset     (reset),
        .bus       (bus)
    );

    always #20 clk = ~clk;

    wire [11:0] rgb = {bus.vga_r, bus.vga_g, bus.vga_b};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_frame();
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        nf++;
    endtask

    task automatic test_reset();
        bus.hsync_in     = 1'b1;
        bus.vsync_in     = 1'b1;
        bus.display_en   = 1'b0;
        bus.frame_start  = 1'b0;
        bus.layer_active = 4'b0000;
        bus.layer_rgb    = '0;
        bus.cfg_layer_en = 4'b1111;
        bus.cfg_blink    = 4'b0000;
        bus.cfg_bg_rgb   = 12'h000;
        bus.cfg_dim      = 1'b0;
        reset = 1'b1;
        tick(); tick();
        checks++;
        if (rgb !== 12'h000) begin failures++; $display("FAIL reset_rgb got=%h exp=000", rgb); end
        checks++;
        if ({bus.vga_hsync, bus.vga_vsync} !== 2'b11) begin failures++; $display("FAIL reset_sync got=%b exp=11", {bus.vga_hsync, bus.vga_vsync}); end
        checks++;
        if (bus.collision !== 4'b0000) begin failures++; $display("FAIL reset_collision got=%b exp=0000", bus.collision); end
        reset = 1'b0;
        nf = 0;
        tick();
    endtask

    task automatic test_background();
        bus.cfg_bg_rgb = 12'hF00;
        pulse_frame();
        bus.display_en = 1'b1;
        tick();
        checks++;
        if (rgb !== 12'h000) begin failures++; $display("FAIL bg_latency1 got=%h exp=000", rgb); end
        tick();
        checks++;
        if (rgb !== 12'hF00) begin failures++; $display("FAIL bg_colour got=%h exp=F00", rgb); end
    endtask

    task automatic test_priority();
        bus.layer_active = 4'b0110;
        bus.layer_rgb    = {12'h000, 12'h00F, 12'h0F0, 12'h000};
        tick(); tick();
        checks++;
        if (rgb !== 12'h0F0) begin failures++; $display("FAIL prio_l1 got=%h exp=0F0", rgb); end
        checks++;
        if (bus.collision !== 4'b0000) begin failures++; $display("FAIL coll_before got=%b exp=0000", bus.collision); end
        pulse_frame();
        checks++;
        if (bus.collision !== 4'b0110) begin failures++; $display("FAIL coll_after got=%b exp=0110", bus.collision); end
        bus.layer_active = 4'b1111;
        bus.layer_rgb    = {12'h111, 12'h00F, 12'h0F0, 12'hABC};
        tick(); tick();
        checks++;
        if (rgb !== 12'hABC) begin failures++; $display("FAIL prio_l0 got=%h exp=ABC", rgb); end
        bus.layer_active = 4'b1000;
        tick(); tick();
        checks++;
        if (rgb !== 12'h111) begin failures++; $display("FAIL prio_l3 got=%h exp=111", rgb); end
        bus.layer_active = 4'b0000;
        pulse_frame();
        checks++;
        if (bus.collision !== 4'b1111) begin failures++; $display("FAIL coll_all got=%b exp=1111", bus.collision); end
        pulse_frame();
        checks++;
        if (bus.collision !== 4'b0000) begin failures++; $display("FAIL coll_clear got=%b exp=0000", bus.collision); end
    endtask

    task automatic test_shadow();
        bus.layer_active = 4'b0001;
        bus.layer_rgb    = {12'h000, 12'h000, 12'h000, 12'h123};
        tick(); tick();
        bus.cfg_layer_en = 4'b1110;
        tick(); tick();
        checks++;
        if (rgb !== 12'h123) begin failures++; $display("FAIL shadow_midframe got=%h exp=123", rgb); end
        pulse_frame();
        tick();
        checks++;
        if (rgb !== 12'h123) begin failures++; $display("FAIL shadow_fs_cycle got=%h exp=123", rgb); end
        tick();
        checks++;
        if (rgb !== 12'hF00) begin failures++; $display("FAIL shadow_applied got=%h exp=F00", rgb); end
        bus.cfg_layer_en = 4'b1111;
        pulse_frame();
    endtask

    task automatic test_blink();
        logic [11:0] exp;
        bus.cfg_blink = 4'b0001;
        pulse_frame();
        for (int f = 0; f < 36; f++) begin
            pulse_frame();
            tick(); tick();
            exp = ((nf >> 4) & 1) != 0 ? 12'hF00 : 12'h123;
            checks++;
            if (rgb !== exp) begin failures++; $display("FAIL blink frame=%0d got=%h exp=%h", nf, rgb, exp); end
        end
        bus.cfg_blink = 4'b0000;
        pulse_frame();
    endtask

    task automatic test_dim();
        bus.layer_active = 4'b0000;
        bus.cfg_bg_rgb   = 12'hFA5;
        bus.cfg_dim      = 1'b1;
        pulse_frame();
        tick(); tick();
        checks++;
        if (rgb !== 12'h752) begin failures++; $display("FAIL dim got=%h exp=752", rgb); end
        bus.display_en = 1'b0;
        bus.hsync_in   = 1'b0;
        bus.vsync_in   = 1'b0;
        tick();
        checks++;
        if ({bus.vga_hsync, bus.vga_vsync} !== 2'b11) begin failures++; $display("FAIL sync_delay1 got=%b exp=11", {bus.vga_hsync, bus.vga_vsync}); end
        tick();
        checks++;
        if ({bus.vga_hsync, bus.vga_vsync} !== 2'b00) begin failures++; $display("FAIL sync_delay2 got=%b exp=00", {bus.vga_hsync, bus.vga_vsync}); end
        checks++;
        if (rgb !== 12'h000) begin failures++; $display("FAIL blank got=%h exp=000", rgb); end
    endtask

    task automatic test_reset_mid();
        bus.display_en = 1'b1;
        bus.vsync_in   = 1'b1;
        tick(); tick();
        checks++;
        if (rgb !== 12'h752 || bus.vga_hsync !== 1'b0) begin failures++; $display("FAIL pre_reset got=%h/%b exp=752/0", rgb, bus.vga_hsync); end
        #5;
        reset = 1'b1;
        #1;
        checks++;
        if (rgb !== 12'h000) begin failures++; $display("FAIL midreset_rgb got=%h exp=000", rgb); end
        checks++;
        if ({bus.vga_hsync, bus.vga_vsync} !== 2'b11) begin failures++; $display("FAIL midreset_sync got=%b exp=11", {bus.vga_hsync, bus.vga_vsync}); end
        tick();
        reset = 1'b0;
        bus.hsync_in = 1'b1;
        tick(); tick();
        checks++;
        if (rgb !== 12'h000) begin failures++; $display("FAIL post_reset_bg got=%h exp=000", rgb); end
        pulse_frame();
        tick(); tick();
        checks++;
        if (rgb !== 12'h752) begin failures++; $display("FAIL post_reset_load got=%h exp=752", rgb); end
    endtask

    initial begin
        test_reset();
        test_background();
        test_priority();
        test_shadow();
        test_blink();
        test_dim();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
